// File: rtl/frame_spill_unit_if.sv
// Data-memory port used by the frame spill unit: one word per accepted cycle,
// with write/read requests held until the memory raises mem_ready.
interface frame_spill_unit_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/frame_spill_unit.sv
// Spills the register-file call frame to a memory stack word by word and
// reloads it on restore, stalling the core through busy while transferring.
module frame_spill_unit #(
  parameter int          WORD_W     = 16,
  parameter int          NUM_WORDS  = 15,
  parameter logic [15:0] STACK_BASE = 16'hF000,
  parameter int          MAX_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          save_req,
  input  logic                          restore_req,
  input  logic [WORD_W*NUM_WORDS-1:0]   frame_in,
  output logic [WORD_W*NUM_WORDS-1:0]   frame_out,
  output logic                          restore,
  output logic                          busy,
  output logic                          done,
  output logic                          err_overflow,
  output logic                          err_underflow,
  output logic [4:0]                    depth,
  frame_spill_unit_if.master            mem
);

  localparam int               CNT_W      = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);
  localparam logic [4:0]       DEPTH_MAX  = 5'(MAX_DEPTH);
  localparam logic [15:0]      FRAME_STEP = 16'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SAVE  = 2'd1,
    S_LOAD  = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [WORD_W-1:0]           shadow [NUM_WORDS];
  logic [WORD_W*NUM_WORDS-1:0] frame_merged;
  logic [CNT_W-1:0]            cnt;
  logic [15:0]                 sp;
  logic                        go_save;
  logic                        go_load;
  logic                        last_beat;

  // Request decode: save wins over restore, full/empty stack rejects.
  always_comb begin
    go_save   = (state == S_IDLE) && save_req && (depth != DEPTH_MAX);
    go_load   = (state == S_IDLE) && !save_req && restore_req && (depth != 5'd0);
    last_beat = mem.mem_ready && (cnt == LAST_IDX);
  end

  // The final read word bypasses the shadow so frame_out is complete in APPLY.
  always_comb begin
    frame_merged = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (CNT_W'(i) == cnt) begin
        frame_merged[i*WORD_W +: WORD_W] = mem.mem_rdata;
      end else begin
        frame_merged[i*WORD_W +: WORD_W] = shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go_save) begin
          state_nxt = S_SAVE;
        end else if (go_load) begin
          state_nxt = S_LOAD;
        end
      end
      S_SAVE: begin
        if (last_beat) begin
          state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (last_beat) begin
          state_nxt = S_APPLY;
        end
      end
      S_APPLY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    restore       = (state == S_APPLY);
    done          = ((state == S_SAVE) && last_beat) || (state == S_APPLY);
    mem.mem_we    = (state == S_SAVE);
    mem.mem_re    = (state == S_LOAD);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state == S_SAVE) begin
      mem.mem_addr  = sp + 16'(cnt);
      mem.mem_wdata = shadow[cnt];
    end else if (state == S_LOAD) begin
      mem.mem_addr  = sp + 16'(cnt);
    end
  end

  // Shadow frame: snapshot on save acceptance, filled word by word on load.
  always_ff @(posedge clk) begin
    if (go_save) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow[i] <= frame_in[i*WORD_W +: WORD_W];
      end
    end else if ((state == S_LOAD) && mem.mem_ready) begin
      shadow[cnt] <= mem.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp            <= STACK_BASE;
      depth         <= 5'd0;
      cnt           <= '0;
      frame_out     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= (state == S_IDLE) && save_req && (depth == DEPTH_MAX);
      err_underflow <= (state == S_IDLE) && !save_req && restore_req && (depth == 5'd0);

      if (go_save) begin
        cnt <= '0;
      end

      // The stack pointer drops on load entry so addresses count upward.
      if (go_load) begin
        sp    <= sp - FRAME_STEP;
        depth <= depth - 5'd1;
        cnt   <= '0;
      end

      if (((state == S_SAVE) || (state == S_LOAD)) && mem.mem_ready) begin
        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end

      if ((state == S_SAVE) && last_beat) begin
        sp    <= sp + FRAME_STEP;
        depth <= depth + 5'd1;
      end

      if ((state == S_LOAD) && last_beat) begin
        frame_out <= frame_merged;
      end
    end
  end

endmodule

// File: tb/tb_frame_spill_unit.sv
// Randomized bench for frame_spill_unit: a LIFO frame-stack model predicts
// every memory beat, restore frame, pulse and stack depth.
module tb_frame_spill_unit;

  logic         clk;
  logic         rst_n;
  logic         save_req;
  logic         restore_req;
  logic [239:0] frame_in;
  logic [239:0] frame_out;
  logic         restore;
  logic         busy;
  logic         done;
  logic         err_overflow;
  logic         err_underflow;
  logic [4:0]   depth;

  frame_spill_unit_if mif ();

  frame_spill_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .save_req     (save_req),
    .restore_req  (restore_req),
    .frame_in     (frame_in),
    .frame_out    (frame_out),
    .restore      (restore),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .depth        (depth),
    .mem          (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem_arr [65536];
  assign mif.mem_rdata = mem_arr[mif.mem_addr];
  always @(posedge clk) begin
    if (mif.mem_we && mif.mem_ready) mem_arr[mif.mem_addr] <= mif.mem_wdata;
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [239:0] stk [$];
  logic [31:0]  exp_wr [$];
  logic [15:0]  exp_rd [$];
  logic [239:0] exp_frames [$];
  logic [31:0]  wr_log [$];
  logic [15:0]  rd_log [$];
  logic [239:0] last_frame = '0;
  int           depth_m = 0;
  int           wait_cnt = 0;
  int           wr_cnt = 0;
  logic         restore_due = 1'b0;
  logic         ovf_exp = 1'b0;
  logic         unf_exp = 1'b0;
  logic [15:0]  stall_addr = '0;

  task automatic chk(input string name, input logic [239:0] act, input logic [239:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [239:0] rand_frame();
    logic [239:0] r;
    for (int i = 0; i < 15; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  function automatic logic pick(input int mode, input int j);
    if (mode == 0) return 1'b1;
    if (mode == 2) return !(j >= 6 && j <= 8);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Per-cycle compare against the frame-stack model, sampled late in the cycle.
  initial begin
    logic exp_r;
    logic exp_done;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        chk("we_re_exclusive", 240'(mif.mem_we & mif.mem_re), 240'(0));
        exp_r       = restore_due;
        restore_due = 1'b0;
        exp_done    = exp_r;
        if (mif.mem_we) begin
          if (exp_wr.size() == 0) begin
            fail("unexpected_write");
          end else begin
            chk("wr_addr", 240'(mif.mem_addr), 240'(exp_wr[0][31:16]));
            chk("wr_data", 240'(mif.mem_wdata), 240'(exp_wr[0][15:0]));
            if (mif.mem_ready) begin
              wr_log.push_back({mif.mem_addr, mif.mem_wdata});
              void'(exp_wr.pop_front());
              if (wr_cnt == 14) begin
                exp_done = 1'b1;
                wr_cnt   = 0;
              end else begin
                wr_cnt++;
              end
            end else begin
              wait_cnt++;
              stall_addr = mif.mem_addr;
            end
          end
        end
        if (mif.mem_re) begin
          if (exp_rd.size() == 0) begin
            fail("unexpected_read");
          end else begin
            chk("rd_addr", 240'(mif.mem_addr), 240'(exp_rd[0]));
            if (mif.mem_ready) begin
              rd_log.push_back(mif.mem_addr);
              void'(exp_rd.pop_front());
              if (exp_rd.size() == 0) restore_due = 1'b1;
            end else begin
              wait_cnt++;
            end
          end
        end
        chk("restore", 240'(restore), 240'(exp_r));
        chk("done", 240'(done), 240'(exp_done));
        if (restore) begin
          if (exp_frames.size() == 0) fail("unexpected_restore");
          else last_frame = exp_frames.pop_front();
        end
        chk("frame_out", frame_out, last_frame);
        chk("err_overflow", 240'(err_overflow), 240'(ovf_exp));
        chk("err_underflow", 240'(err_underflow), 240'(unf_exp));
        if (!busy) begin
          chk("depth_idle", 240'(depth), 240'(depth_m));
          chk("idle_bus", 240'({mif.mem_we, mif.mem_re}), 240'(0));
        end
      end
    end
  end

  task automatic do_op(input bit sv, input bit rs, input logic [239:0] f, input int mode,
                       output int cycles);
    int          kind;
    logic [15:0] base;
    logic [239:0] fr;
    kind = 0;
    if (sv) kind = (depth_m < 16) ? 1 : 3;
    else if (rs) kind = (depth_m > 0) ? 2 : 4;
    if (kind == 1) begin
      base = 16'hF000 + 16'(15 * depth_m);
      for (int i = 0; i < 15; i++) exp_wr.push_back({base + 16'(i), f[i*16 +: 16]});
      stk.push_back(f);
    end
    if (kind == 2) begin
      fr   = stk.pop_back();
      base = 16'hF000 + 16'(15 * (depth_m - 1));
      for (int i = 0; i < 15; i++) exp_rd.push_back(base + 16'(i));
      exp_frames.push_back(fr);
    end
    @(negedge clk);
    save_req    = sv;
    restore_req = rs;
    frame_in    = f;
    wait_cnt    = 0;
    @(negedge clk);
    save_req    = 1'b0;
    restore_req = 1'b0;
    frame_in    = rand_frame();
    ovf_exp     = (kind == 3);
    unf_exp     = (kind == 4);
    chk("busy_start", 240'(busy), 240'(kind == 1 || kind == 2));
    cycles = 0;
    while (busy && cycles < 300) begin
      cycles++;
      mif.mem_ready = pick(mode, cycles);
      @(negedge clk);
    end
    if (cycles >= 300) fail("busy_timeout");
    mif.mem_ready = 1'b0;
    if (kind == 1) begin
      chk("save_busy_cycles", 240'(cycles), 240'(15 + wait_cnt));
      depth_m++;
    end
    if (kind == 2) begin
      chk("restore_busy_cycles", 240'(cycles), 240'(16 + wait_cnt));
      depth_m--;
    end
    @(negedge clk);
    ovf_exp = 1'b0;
    unf_exp = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [239:0] f1;
    logic [15:0]  tgt;
    int           c;
    int           idx;
    int           n;
    int           r;
    rst_n         = 1'b0;
    save_req      = 1'b0;
    restore_req   = 1'b0;
    frame_in      = '0;
    mif.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 240'(busy), 240'(0));
    chk("rst_depth", 240'(depth), 240'(0));
    chk("rst_frame_out", frame_out, 240'(0));
    chk("rst_bus", 240'({mif.mem_we, mif.mem_re, mif.mem_addr, mif.mem_wdata}), 240'(0));
    chk("rst_pulses", 240'({restore, done, err_overflow, err_underflow}), 240'(0));
    rst_n = 1'b1;

    // Test 1: frame of 0100+i with memory always ready
    for (int i = 0; i < 15; i++) f1[i*16 +: 16] = 16'h0100 + 16'(i);
    do_op(1'b1, 1'b0, f1, 0, c);
    chk("t1_busy15", 240'(c), 240'(15));
    chk("t1_first_write", 240'(wr_log[0]), 240'(32'hF000_0100));
    chk("t1_last_write", 240'(wr_log[14]), 240'(32'hF00E_010E));
    chk("t1_depth", 240'(depth), 240'(1));

    // Test 2: restore returns the saved frame
    do_op(1'b0, 1'b1, rand_frame(), 0, c);
    chk("t2_busy16", 240'(c), 240'(16));
    chk("t2_first_read", 240'(rd_log[0]), 240'(16'hF000));
    chk("t2_last_read", 240'(rd_log[14]), 240'(16'hF00E));
    chk("t2_frame_out", frame_out, f1);
    chk("t2_depth", 240'(depth), 240'(0));

    // Test 4a: restore on an empty stack
    do_op(1'b0, 1'b1, rand_frame(), 0, c);
    chk("t4_underflow_depth", 240'(depth), 240'(0));

    // Test 3: three wait cycles on word 5
    do_op(1'b1, 1'b0, rand_frame(), 2, c);
    chk("t3_busy18", 240'(c), 240'(18));
    chk("t3_stall_addr", 240'(stall_addr), 240'(16'hF005));

    // Test 5: simultaneous requests at depth 1
    idx = wr_log.size();
    do_op(1'b1, 1'b1, rand_frame(), 0, c);
    chk("t5_save_won", 240'(wr_log[idx][31:16]), 240'(16'hF00F));
    chk("t5_depth", 240'(depth), 240'(2));

    // Test 4b: fill the stack, then overflow
    while (depth_m < 16) do_op(1'b1, 1'b0, rand_frame(), 1, c);
    do_op(1'b1, 1'b0, rand_frame(), 1, c);
    chk("t4_overflow_depth", 240'(depth), 240'(16));
    do_op(1'b1, 1'b1, rand_frame(), 1, c);
    chk("t4_overflow_both_depth", 240'(depth), 240'(16));

    // Random mix of saves and restores with random memory stalls
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      do_op((r < 4) || (r == 9), r >= 4, rand_frame(), 1, c);
    end

    // Test 6: reset in the middle of a load
    if (depth_m == 0) do_op(1'b1, 1'b0, rand_frame(), 1, c);
    tgt = 16'hF000 + 16'(15 * (depth_m - 1)) + 16'd7;
    for (int i = 0; i < 15; i++) exp_rd.push_back(tgt - 16'd7 + 16'(i));
    exp_frames.push_back(stk.pop_back());
    @(negedge clk);
    restore_req   = 1'b1;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    restore_req = 1'b0;
    n = 0;
    while (!(mif.mem_re && mif.mem_addr == tgt) && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) fail("t6_word7_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 240'(busy), 240'(0));
    chk("t6_mem_re", 240'(mif.mem_re), 240'(0));
    chk("t6_restore", 240'(restore), 240'(0));
    chk("t6_depth", 240'(depth), 240'(0));
    exp_rd.delete();
    exp_frames.delete();
    stk.delete();
    depth_m       = 0;
    restore_due   = 1'b0;
    last_frame    = '0;
    wr_cnt        = 0;
    mif.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idx = wr_log.size();
    do_op(1'b1, 1'b0, rand_frame(), 1, c);
    chk("t6_next_save_addr", 240'(wr_log[idx][31:16]), 240'(16'hF000));
    chk("t6_depth_after", 240'(depth), 240'(1));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
